// File: rtl/clock_alarm_core.sv
// Timekeeping core: prescaled seconds, BCD time, 6-state adjust FSM,
// 12/24-hour display mapping, hourly chime and dismissable alarm.
module clock_alarm_core #(
  parameter int CLK_FREQ    = 100000000,
  parameter int CHIME_SECS  = 5,
  parameter int ALARM_SECS  = 30,
  parameter int ALARM_H_RST = 7,
  parameter int ALARM_M_RST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_p,
  input  logic       inc_p,
  input  logic       h12,
  input  logic       alarm_en,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       pm,
  output logic [2:0] adj_field,
  output logic       flash,
  output logic       sec_tick,
  output logic       chime,
  output logic       alarm_ring
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam int HW = $clog2(CLK_FREQ / 2);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [HW-1:0] HALF_MAX  = HW'(CLK_FREQ / 2 - 1);
  localparam logic [7:0]    AH_RST    = {4'(ALARM_H_RST / 10), 4'(ALARM_H_RST % 10)};
  localparam logic [7:0]    AM_RST    = {4'(ALARM_M_RST / 10), 4'(ALARM_M_RST % 10)};
  localparam logic [5:0]    CHIME_LD  = 6'(CHIME_SECS);
  localparam logic [5:0]    ALARM_LD  = 6'(ALARM_SECS);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_ADJ_H  = 3'd1,
    S_ADJ_M  = 3'd2,
    S_ADJ_S  = 3'd3,
    S_ADJ_AH = 3'd4,
    S_ADJ_AM = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] half_q, half_d;
  logic          flash_q, flash_d;
  logic          tick_q, tick_d;
  logic [7:0]    hr_q, hr_d;
  logic [7:0]    mn_q, mn_d;
  logic [7:0]    sc_q, sc_d;
  logic [7:0]    ah_q, ah_d;
  logic [7:0]    am_q, am_d;
  logic          chime_q, chime_d;
  logic [5:0]    chime_cnt_q, chime_cnt_d;
  logic          ring_q, ring_d;
  logic [5:0]    ring_cnt_q, ring_cnt_d;

  logic counting;
  logic wrap;
  logic half_wrap;

  // Wrapping BCD increment of a two-digit field whose top value is max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) begin
      return 8'h00;
    end
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Internal 24-hour BCD hour to its 12-hour BCD display form.
  function automatic logic [7:0] to_12h(input logic [7:0] h);
    int b;
    b = int'(h[7:4]) * 10 + int'(h[3:0]);
    if (b == 0) begin
      b = 12;
    end else if (b > 12) begin
      b = b - 12;
    end
    return {4'(b / 10), 4'(b % 10)};
  endfunction

  function automatic state_t next_state(input state_t s);
    case (s)
      S_RUN:    return S_ADJ_H;
      S_ADJ_H:  return S_ADJ_M;
      S_ADJ_M:  return S_ADJ_S;
      S_ADJ_S:  return S_ADJ_AH;
      S_ADJ_AH: return S_ADJ_AM;
      default:  return S_RUN;
    endcase
  endfunction

  assign counting  = (state_q == S_RUN) && run;
  assign wrap      = counting && (presc_q == PRESC_MAX);
  assign half_wrap = (half_q == HALF_MAX);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    half_d      = half_wrap ? '0 : half_q + 1'b1;
    flash_d     = flash_q;
    tick_d      = wrap;
    hr_d        = hr_q;
    mn_d        = mn_q;
    sc_d        = sc_q;
    ah_d        = ah_q;
    am_d        = am_q;
    chime_d     = chime_q;
    chime_cnt_d = chime_cnt_q;
    ring_d      = ring_q;
    ring_cnt_d  = ring_cnt_q;

    if (counting) begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
    end

    // Second boundary: advance time, then run the countdowns and triggers
    // against the freshly advanced time.
    if (wrap) begin
      sc_d = bcd_inc(sc_q, 8'h59);
      if (sc_q == 8'h59) begin
        mn_d = bcd_inc(mn_q, 8'h59);
        if (mn_q == 8'h59) begin
          hr_d = bcd_inc(hr_q, 8'h23);
        end
      end

      if (chime_q) begin
        chime_cnt_d = chime_cnt_q - 1'b1;
        if (chime_cnt_q == 6'd1) begin
          chime_d = 1'b0;
        end
      end
      if (mn_d == 8'h00 && sc_d == 8'h00) begin
        chime_d     = 1'b1;
        chime_cnt_d = CHIME_LD;
      end

      if (ring_q) begin
        ring_cnt_d = ring_cnt_q - 1'b1;
        if (ring_cnt_q == 6'd1) begin
          ring_d = 1'b0;
        end
      end
      if (alarm_en && hr_d == ah_q && mn_d == am_q && sc_d == 8'h00) begin
        ring_d     = 1'b1;
        ring_cnt_d = ALARM_LD;
      end
    end

    if (state_q == S_RUN) begin
      flash_d = 1'b1;
    end else if (half_wrap) begin
      flash_d = ~flash_q;
    end

    // mode_p takes precedence over inc_p in the same cycle.
    if (mode_p) begin
      state_d = next_state(state_q);
      flash_d = 1'b1;
      ring_d  = 1'b0;
      if (state_q == S_ADJ_AM) begin
        presc_d = '0;
      end
    end else if (inc_p) begin
      case (state_q)
        S_RUN:    ring_d = 1'b0;
        S_ADJ_H:  hr_d   = bcd_inc(hr_q, 8'h23);
        S_ADJ_M:  mn_d   = bcd_inc(mn_q, 8'h59);
        S_ADJ_S:  sc_d   = 8'h00;
        S_ADJ_AH: ah_d   = bcd_inc(ah_q, 8'h23);
        S_ADJ_AM: am_d   = bcd_inc(am_q, 8'h59);
        default:  ;
      endcase
    end

    if (!alarm_en) begin
      ring_d = 1'b0;
    end
    if (!ring_d) begin
      ring_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_RUN;
      presc_q     <= '0;
      half_q      <= '0;
      flash_q     <= 1'b1;
      tick_q      <= 1'b0;
      hr_q        <= 8'h00;
      mn_q        <= 8'h00;
      sc_q        <= 8'h00;
      ah_q        <= AH_RST;
      am_q        <= AM_RST;
      chime_q     <= 1'b0;
      chime_cnt_q <= '0;
      ring_q      <= 1'b0;
      ring_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      half_q      <= half_d;
      flash_q     <= flash_d;
      tick_q      <= tick_d;
      hr_q        <= hr_d;
      mn_q        <= mn_d;
      sc_q        <= sc_d;
      ah_q        <= ah_d;
      am_q        <= am_d;
      chime_q     <= chime_d;
      chime_cnt_q <= chime_cnt_d;
      ring_q      <= ring_d;
      ring_cnt_q  <= ring_cnt_d;
    end
  end

  // Alarm fields replace the time on the display while they are being set.
  logic       alarm_view;
  logic [7:0] hr_view;

  assign alarm_view  = (state_q == S_ADJ_AH) || (state_q == S_ADJ_AM);
  assign hr_view     = alarm_view ? ah_q : hr_q;
  assign pm          = (hr_view >= 8'h12);
  assign hours_bcd   = h12 ? to_12h(hr_view) : hr_view;
  assign minutes_bcd = alarm_view ? am_q : mn_q;
  assign seconds_bcd = alarm_view ? 8'h00 : sc_q;
  assign adj_field   = state_q;
  assign flash       = flash_q;
  assign sec_tick    = tick_q;
  assign chime       = chime_q;
  assign alarm_ring  = ring_q;

endmodule

// File: tb/tb_clock_alarm_core.sv
// Directed bench for clock_alarm_core with a 10-cycle second.
module tb_clock_alarm_core;

  logic       clk = 1'b0;
  logic       rst, run, mode_p, inc_p, h12, alarm_en;
  logic [7:0] hours_bcd, minutes_bcd, seconds_bcd;
  logic       pm, flash, sec_tick, chime, alarm_ring;
  logic [2:0] adj_field;

  int n_assert = 0;
  int n_fail   = 0;

  clock_alarm_core #(
    .CLK_FREQ(10), .CHIME_SECS(5), .ALARM_SECS(30), .ALARM_H_RST(7), .ALARM_M_RST(0)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .mode_p(mode_p), .inc_p(inc_p), .h12(h12),
    .alarm_en(alarm_en), .hours_bcd(hours_bcd), .minutes_bcd(minutes_bcd),
    .seconds_bcd(seconds_bcd), .pm(pm), .adj_field(adj_field), .flash(flash),
    .sec_tick(sec_tick), .chime(chime), .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mode_pulse();
    mode_p = 1'b1;
    step(1);
    mode_p = 1'b0;
  endtask

  task automatic inc_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      inc_p = 1'b1;
      step(1);
      inc_p = 1'b0;
    end
  endtask

  initial begin
    logic found;
    rst = 1'b0; run = 1'b0; mode_p = 1'b0; inc_p = 1'b0; h12 = 1'b0; alarm_en = 1'b0;
    step(3);
    chk("rst_hours", hours_bcd, 8'h00);
    chk("rst_minutes", minutes_bcd, 8'h00);
    chk("rst_seconds", seconds_bcd, 8'h00);
    chk("rst_field", adj_field, 3'd0);
    chk("rst_flash", flash, 1'b1);
    chk("rst_tick", sec_tick, 1'b0);
    chk("rst_chime", chime, 1'b0);
    chk("rst_ring", alarm_ring, 1'b0);

    // Tick period and pause
    rst = 1'b1; run = 1'b1;
    step(9);
    chk("tick_pre_sec", seconds_bcd, 8'h00);
    chk("tick_pre", sec_tick, 1'b0);
    step(1);
    chk("tick_sec1", seconds_bcd, 8'h01);
    chk("tick_pulse", sec_tick, 1'b1);
    step(1);
    chk("tick_one_cycle", sec_tick, 1'b0);
    run = 1'b0;
    step(25);
    chk("pause_hold", seconds_bcd, 8'h01);
    run = 1'b1;
    step(8);
    chk("resume_pre", seconds_bcd, 8'h01);
    step(1);
    chk("resume_sec2", seconds_bcd, 8'h02);
    chk("resume_tick", sec_tick, 1'b1);
    run = 1'b0;

    // FSM cycle, hour wrap, simultaneous pulses
    mode_pulse();
    chk("fsm_h", adj_field, 3'd1);
    chk("flash_entry", flash, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (flash == 1'b0) found = 1'b1;
    end
    chk("flash_toggles", found, 1'b1);
    inc_pulses(13);
    chk("adj_h13", hours_bcd, 8'h13);
    inc_pulses(11);
    chk("adj_h_wrap", hours_bcd, 8'h00);
    mode_p = 1'b1; inc_p = 1'b1;
    step(1);
    mode_p = 1'b0; inc_p = 1'b0;
    chk("both_field", adj_field, 3'd2);
    chk("both_hours", hours_bcd, 8'h00);
    chk("both_minutes", minutes_bcd, 8'h00);
    mode_pulse();
    chk("fsm_s", adj_field, 3'd3);
    mode_pulse();
    chk("fsm_ah", adj_field, 3'd4);
    chk("ah_view_hours", hours_bcd, 8'h07);
    chk("ah_view_seconds", seconds_bcd, 8'h00);
    mode_pulse();
    chk("fsm_am", adj_field, 3'd5);
    mode_pulse();
    chk("fsm_run", adj_field, 3'd0);
    chk("run_seconds", seconds_bcd, 8'h02);

    // 12-hour mapping
    mode_pulse();
    h12 = 1'b1;
    step(1);
    chk("h12_00", hours_bcd, 8'h12);
    chk("h12_00_pm", pm, 1'b0);
    inc_pulses(11);
    chk("h12_11", hours_bcd, 8'h11);
    chk("h12_11_pm", pm, 1'b0);
    inc_pulses(1);
    chk("h12_12", hours_bcd, 8'h12);
    chk("h12_12_pm", pm, 1'b1);
    inc_pulses(1);
    chk("h12_13", hours_bcd, 8'h01);
    chk("h12_13_pm", pm, 1'b1);
    inc_pulses(10);
    chk("h12_23", hours_bcd, 8'h11);
    chk("h12_23_pm", pm, 1'b1);
    h12 = 1'b0;
    step(1);
    chk("h24_23", hours_bcd, 8'h23);
    chk("h24_23_pm", pm, 1'b1);
    inc_pulses(1);
    chk("h24_00", hours_bcd, 8'h00);
    chk("h24_00_pm", pm, 1'b0);

    // Full rollover and chime length
    inc_pulses(23);
    mode_pulse();
    inc_pulses(59);
    mode_pulse();
    inc_pulses(1);
    chk("s_clear", seconds_bcd, 8'h00);
    mode_pulse();
    mode_pulse();
    run = 1'b1;
    mode_pulse();
    step(580);
    chk("roll_h", hours_bcd, 8'h23);
    chk("roll_m", minutes_bcd, 8'h59);
    chk("roll_s", seconds_bcd, 8'h58);
    step(10);
    chk("roll_s59", seconds_bcd, 8'h59);
    chk("roll_no_chime", chime, 1'b0);
    step(10);
    chk("roll0_h", hours_bcd, 8'h00);
    chk("roll0_m", minutes_bcd, 8'h00);
    chk("roll0_s", seconds_bcd, 8'h00);
    chk("chime_on", chime, 1'b1);
    step(49);
    chk("chime_held", chime, 1'b1);
    step(1);
    chk("chime_off", chime, 1'b0);
    chk("chime_off_s", seconds_bcd, 8'h05);

    // Alarm: dismissed by inc_p
    mode_pulse();
    mode_pulse();
    mode_pulse();
    inc_pulses(1);
    mode_pulse();
    inc_pulses(17);
    chk("alarm_h_set", hours_bcd, 8'h00);
    mode_pulse();
    inc_pulses(1);
    chk("alarm_m_set", minutes_bcd, 8'h01);
    alarm_en = 1'b1;
    mode_pulse();
    chk("alarm_no_adj_trig", alarm_ring, 1'b0);
    step(580);
    chk("al_s58", seconds_bcd, 8'h58);
    step(19);
    chk("al_pre", alarm_ring, 1'b0);
    step(1);
    chk("al_min", minutes_bcd, 8'h01);
    chk("al_ring", alarm_ring, 1'b1);
    step(30);
    chk("al_ring3", alarm_ring, 1'b1);
    chk("al_s03", seconds_bcd, 8'h03);
    inc_pulses(1);
    chk("al_dismiss", alarm_ring, 1'b0);

    // Alarm: expires by countdown
    mode_pulse();
    mode_pulse();
    mode_pulse();
    inc_pulses(1);
    mode_pulse();
    mode_pulse();
    inc_pulses(1);
    chk("alarm_m2_set", minutes_bcd, 8'h02);
    mode_pulse();
    step(599);
    chk("al2_pre", alarm_ring, 1'b0);
    step(1);
    chk("al2_ring", alarm_ring, 1'b1);
    step(299);
    chk("al2_held", alarm_ring, 1'b1);
    step(1);
    chk("al2_expire", alarm_ring, 1'b0);
    chk("al2_s30", seconds_bcd, 8'h30);

    // Reset during an active chime in ADJ_M
    mode_pulse();
    mode_pulse();
    inc_pulses(57);
    chk("rs_m59", minutes_bcd, 8'h59);
    mode_pulse();
    inc_pulses(1);
    mode_pulse();
    mode_pulse();
    mode_pulse();
    step(600);
    chk("rs_h01", hours_bcd, 8'h01);
    chk("rs_chime", chime, 1'b1);
    mode_pulse();
    mode_pulse();
    chk("rs_in_m", adj_field, 3'd2);
    chk("rs_chime_adj", chime, 1'b1);
    rst = 1'b0;
    step(1);
    chk("rs_hours", hours_bcd, 8'h00);
    chk("rs_minutes", minutes_bcd, 8'h00);
    chk("rs_seconds", seconds_bcd, 8'h00);
    chk("rs_field", adj_field, 3'd0);
    chk("rs_chime_clr", chime, 1'b0);
    chk("rs_ring_clr", alarm_ring, 1'b0);
    rst = 1'b1;
    mode_pulse();
    mode_pulse();
    mode_pulse();
    mode_pulse();
    chk("rs_alarm_h", hours_bcd, 8'h07);
    chk("rs_alarm_m", minutes_bcd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
